// File: rtl/stack_cpu_pkg.sv
// stack_cpu_pkg: opcode, FSM state and fault code definitions shared by the stack CPU core and ALU
package stack_cpu_pkg;
    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,
        OP_PUSH = 6'd1,
        OP_POP  = 6'd2,
        OP_ADD  = 6'd3,
        OP_OR   = 6'd4,
        OP_SUB  = 6'd5,
        OP_SLT  = 6'd6,
        OP_NOR  = 6'd7,
        OP_AND  = 6'd8,
        OP_DUP  = 6'd9,
        OP_SWAP = 6'd10,
        OP_JZ   = 6'd11,
        OP_JMP  = 6'd12,
        OP_HALT = 6'd63
    } opcode_t;

    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_t;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_OVF  = 2'b01;
    localparam logic [1:0] FAULT_UNF  = 2'b10;
    localparam logic [1:0] FAULT_ILL  = 2'b11;
endpackage

// File: rtl/stack_cpu_alu.sv
// stack_cpu_alu: combinational binary-op unit computing a op b for opcodes ADD..AND
//   a, b     in  DATA_W  operands (a = stack[sp-2], b = stack[sp-1])
//   op       in  6       opcode
//   result   out DATA_W  a op b
//   is_zero  out 1       result == 0
module stack_cpu_alu
    import stack_cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [5:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              is_zero
);
    always_comb begin
        result  = op == OP_ADD ? a + b :
                  op == OP_OR  ? a | b :
                  op == OP_SUB ? a - b :
                  op == OP_SLT ? DATA_W'($signed(a) < $signed(b)) :
                  op == OP_NOR ? ~(a | b) :
                  op == OP_AND ? a & b : '0;
        is_zero = result == '0;
    end
endmodule

// File: rtl/stack_cpu_core.sv
// stack_cpu_core: single-issue stack processor with JMP/JZ, DUP/SWAP, HALT and fault detection
//   clock        in  1       rising-edge clock
//   reset_n      in  1       asynchronous active-low reset
//   instr_addr   out PC_W    program counter, addresses combinational instruction memory
//   instr_in     in  32      instruction at instr_addr
//   top          out DATA_W  stack[sp-1], 0 when empty
//   zero         out 1       last binary-op result / JZ operand was zero
//   sp           out         stack occupancy 0..DEPTH
//   halted       out 1       core in HALT
//   fault        out 1       core in FAULT
//   fault_code   out 2       01 overflow, 10 underflow, 11 illegal opcode
// Build option: STACK_CPU_SIGNED_IMM_EN sign-extends the PUSH immediate (zero-extended otherwise).
module stack_cpu_core
    import stack_cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int PC_W   = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic [PC_W-1:0]        instr_addr,
    input  logic [31:0]            instr_in,
    output logic [DATA_W-1:0]      top,
    output logic                   zero,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   halted,
    output logic                   fault,
    output logic [1:0]             fault_code
);
    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;

    state_t            state, state_n;
    logic [1:0]        code_n;
    logic [DATA_W-1:0] stk [DEPTH];
    logic [PC_W-1:0]   pc;
    logic [5:0]        op;
    logic [15:0]       imm;
    logic [AW-1:0]     i0, i1, i2;
    logic [DATA_W-1:0] a, b, imm_ext, push_val, alu_res;
    logic              alu_zero, is_bin, is_push, ovf, unf, ill, exec;
    logic              unused;

    assign op     = instr_in[31:26];
    assign imm    = instr_in[15:0];
    assign unused = ^instr_in[25:16];

`ifdef STACK_CPU_SIGNED_IMM_EN
    assign imm_ext = DATA_W'($signed(imm));
`else
    assign imm_ext = DATA_W'(imm);
`endif

    stack_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a       (a),
        .b       (b),
        .op      (op),
        .result  (alu_res),
        .is_zero (alu_zero)
    );

    always_comb begin
        i0       = sp[AW-1:0];
        i1       = i0 - 1'b1;
        i2       = i1 - 1'b1;
        a        = stk[i2];
        b        = stk[i1];
        top      = sp == '0 ? '0 : b;
        // DUP on an empty stack is legal and pushes the visible top, i.e. 0
        push_val = op == OP_DUP ? top : imm_ext;
        is_bin   = op >= OP_ADD && op <= OP_AND;
        is_push  = op == OP_PUSH || op == OP_DUP;
        ill      = !(op <= OP_JMP || op == OP_HALT);
        ovf      = is_push && sp == SP_W'(DEPTH);
        unf      = ((op == OP_POP || op == OP_JZ) && sp == '0) ||
                   ((is_bin || op == OP_SWAP) && sp < SP_W'(2));
        exec     = state == ST_RUN && !ill && !ovf && !unf && op != OP_HALT;
        state_n  = state != ST_RUN ? state :
                   (ill || ovf || unf) ? ST_FAULT :
                   op == OP_HALT ? ST_HALT : ST_RUN;
        code_n   = state != ST_RUN ? fault_code :
                   ill ? FAULT_ILL : ovf ? FAULT_OVF : unf ? FAULT_UNF : FAULT_NONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) stk[k] <= '0;
        end else if (exec) begin
            if (is_push) stk[i0] <= push_val;
            if (is_bin) stk[i2] <= alu_res;
            if (op == OP_SWAP) begin
                stk[i2] <= b;
                stk[i1] <= a;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            fault_code <= FAULT_NONE;
            pc         <= '0;
            sp         <= '0;
            zero       <= 1'b0;
        end else begin
            state      <= state_n;
            fault_code <= code_n;
            if (exec) begin
                pc   <= (op == OP_JMP || (op == OP_JZ && b == '0)) ? imm[PC_W-1:0] : pc + 1'b1;
                sp   <= is_push ? sp + 1'b1 : (is_bin || op == OP_POP || op == OP_JZ) ? sp - 1'b1 : sp;
                zero <= is_bin ? alu_zero : op == OP_JZ ? b == '0 : zero;
            end
        end
    end

    assign instr_addr = pc;
    assign halted     = state == ST_HALT;
    assign fault      = state == ST_FAULT;
endmodule
